// File: rtl/lane_scan_pkg.sv
// -----------------------------------------------------------------------------
// lane_scan_pkg
// Shared types and helpers for the lane scan capture bank.
//   lane_scan_state_e : FSM state encoding (IDLE, SCAN)
//   LS_MODE_SINGLE/CONT : values of the latched sweep mode
//   ls_idx_width()    : lane index width for a given lane count (min 1 bit)
// -----------------------------------------------------------------------------
package lane_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } lane_scan_state_e;

    localparam logic LS_MODE_SINGLE = 1'b0;
    localparam logic LS_MODE_CONT   = 1'b1;

    // A single-lane bank still needs a 1-bit index port.
    function automatic int ls_idx_width(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_scan_ctr.sv
// -----------------------------------------------------------------------------
// lane_scan_ctr
// Lane index counter: counts 0..NUM_LANES-1 and wraps to 0.
// Ports:
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   i_clr           : force index to 0 (has priority over i_inc)
//   i_inc           : advance index (wrap after the last lane)
//   o_idx           : current index
//   o_tc            : terminal count, high while o_idx == NUM_LANES-1
// -----------------------------------------------------------------------------
module lane_scan_ctr
    import lane_scan_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int IDX_W     = ls_idx_width(NUM_LANES)
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_tc
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // With one lane LAST_IDX is 0, so the counter never leaves 0.
    assign o_tc  = (idx_q == LAST_IDX);
    assign o_idx = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (i_clr) begin
            idx_d = '0;
        end else if (i_inc) begin
            idx_d = o_tc ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/lane_scan_capture.sv
// -----------------------------------------------------------------------------
// lane_scan_capture
// Sweeps a lane index over NUM_LANES input lanes and registers one lane per
// enabled clock into a per-lane output register. Single-sweep or continuous
// mode, start/busy/done handshake and synchronous abort.
// Optional feature macro: LANE_SCAN_PARITY_EN (adds o_par, per-lane even
// parity of o_lane_q).
// Ports:
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   i_en            : scan enable (pauses the sweep when low)
//   i_start, i_mode : sweep request and mode (0 single, 1 continuous), IDLE only
//   i_abort         : return to IDLE without capture or done
//   i_data          : lane k at [k*WIDTH +: WIDTH]
//   o_lane_q        : captured lanes, same packing as i_data
//   o_idx           : lane captured at the next enabled edge
//   o_busy          : high while scanning
//   o_done          : one-cycle pulse after the last lane is captured
//   o_par           : per-lane XOR of o_lane_q (macro only)
// -----------------------------------------------------------------------------
module lane_scan_capture
    import lane_scan_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int WIDTH     = 8,
    parameter int IDX_W     = ls_idx_width(NUM_LANES)
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       i_en,
    input  logic                       i_start,
    input  logic                       i_mode,
    input  logic                       i_abort,
    input  logic [NUM_LANES*WIDTH-1:0] i_data,
    output logic [NUM_LANES*WIDTH-1:0] o_lane_q,
    output logic [IDX_W-1:0]           o_idx,
    output logic                       o_busy,
    output logic                       o_done
`ifdef LANE_SCAN_PARITY_EN
    ,
    output logic [NUM_LANES-1:0]       o_par
`endif
);

    lane_scan_state_e state_q, state_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             cap_en;
    logic             ctr_clr;
    logic             ctr_tc;

    logic [WIDTH-1:0] lane_q [NUM_LANES];
    logic [WIDTH-1:0] lane_d [NUM_LANES];

    lane_scan_ctr #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_ctr (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_clr    (ctr_clr),
        .i_inc    (cap_en),
        .o_idx    (o_idx),
        .o_tc     (ctr_tc)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
            mode_q  <= LS_MODE_SINGLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; abort wins over the end-of-sweep transition.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_d = SCAN;
                    mode_d  = i_mode;
                end
            end
            SCAN: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (i_en && ctr_tc && (mode_q == LS_MODE_SINGLE)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        o_busy  = (state_q == SCAN);
        cap_en  = (state_q == SCAN) && !i_abort && i_en;
        // Index restarts at 0 on an accepted start and on abort.
        ctr_clr = ((state_q == IDLE) && i_start && !i_abort) ||
                  ((state_q == SCAN) && i_abort);
        done_d  = cap_en && ctr_tc;
    end

    assign o_done = done_q;

    // Capture registers: only the lane selected by the index is written.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_d[gi] = (cap_en && (o_idx == IDX_W'(gi)))
                              ? i_data[gi*WIDTH +: WIDTH] : lane_q[gi];
            assign o_lane_q[gi*WIDTH +: WIDTH] = lane_q[gi];
`ifdef LANE_SCAN_PARITY_EN
            assign o_par[gi] = ^lane_q[gi];
`endif
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

endmodule

// File: tb/tb_lane_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_lane_scan_capture
// Self-checking bench for lane_scan_capture (NUM_LANES = 8, WIDTH = 8).
// Define LANE_SCAN_PARITY_EN to also exercise o_par.
// -----------------------------------------------------------------------------
module tb_lane_scan_capture;

    localparam int N = 8;
    localparam int W = 8;

    logic           i_clk    = 1'b0;
    logic           i_arst_n = 1'b0;
    logic           i_en     = 1'b0;
    logic           i_start  = 1'b0;
    logic           i_mode   = 1'b0;
    logic           i_abort  = 1'b0;
    logic [N*W-1:0] i_data   = '0;
    logic [N*W-1:0] o_lane_q;
    logic [2:0]     o_idx;
    logic           o_busy;
    logic           o_done;
`ifdef LANE_SCAN_PARITY_EN
    logic [N-1:0]   o_par;
`endif

    lane_scan_capture #(
        .NUM_LANES (N),
        .WIDTH     (W)
    ) dut (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_en     (i_en),
        .i_start  (i_start),
        .i_mode   (i_mode),
        .i_abort  (i_abort),
        .i_data   (i_data),
        .o_lane_q (o_lane_q),
        .o_idx    (o_idx),
        .o_busy   (o_busy),
        .o_done   (o_done)
`ifdef LANE_SCAN_PARITY_EN
        ,
        .o_par    (o_par)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: which lanes hold what, where the sweep is.
    logic [7:0] m_lane [N];
    int         m_idx;
    bit         m_scan;
    bit         m_cont;
    bit         m_done;

    function automatic logic [N*W-1:0] lanes_of(input logic [7:0] base);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    function automatic logic [N*W+4:0] exp_vec();
        logic [N*W-1:0] lq;
        for (int k = 0; k < N; k++) lq[k*8 +: 8] = m_lane[k];
        return {lq, 3'(m_idx), m_scan, m_done};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_lane[k] = 8'h00;
        m_idx = 0; m_scan = 0; m_cont = 0; m_done = 0;
    endtask

    // One rising edge of the sweep rules, using the inputs present at the edge.
    task automatic model_step();
        m_done = 0;
        if (!m_scan) begin
            if (i_start && !i_abort) begin
                m_scan = 1; m_cont = i_mode; m_idx = 0;
            end
        end else if (i_abort) begin
            m_scan = 0; m_idx = 0;
        end else if (i_en) begin
            m_lane[m_idx] = i_data[m_idx*8 +: 8];
            if (m_idx == N - 1) begin
                m_idx = 0; m_done = 1;
                if (!m_cont) m_scan = 0;
            end else begin
                m_idx = m_idx + 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        i_arst_n = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({o_lane_q, o_idx, o_busy, o_done} !== '0) begin
            errors++;
            $display("FAIL reset_values got=%h want=0", {o_lane_q, o_idx, o_busy, o_done});
        end
        @(posedge i_clk); #1;
        i_arst_n = 1'b1;
        cyc();
        checks++;
        if ({o_lane_q, o_idx, o_busy, o_done} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", {o_lane_q, o_idx, o_busy, o_done}, exp_vec());
        end
        $display("test_reset: done");
    endtask

    task automatic test_single_sweep();
        int done_at = -1;
        int ndone = 0;
        i_data = lanes_of(8'h10); i_mode = 1'b0; i_en = 1'b1; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_idx !== 3'd0) begin
            errors++;
            $display("FAIL single_start busy=%b idx=%0d want busy=1 idx=0", o_busy, o_idx);
        end
        for (int n = 1; n <= 12; n++) begin
            cyc();
            checks++;
            if ({o_lane_q, o_idx, o_busy, o_done} !== exp_vec()) begin
                errors++;
                $display("FAIL single_model n=%0d got=%h want=%h", n, {o_lane_q, o_idx, o_busy, o_done}, exp_vec());
            end
            if (o_done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
        end
        checks++;
        if (done_at != 8 || ndone != 1) begin
            errors++;
            $display("FAIL single_done at=%0d count=%0d want at=8 count=1", done_at, ndone);
        end
        checks++;
        if (o_lane_q !== 64'h1716151413121110 || o_busy !== 1'b0 || o_idx !== 3'd0) begin
            errors++;
            $display("FAIL single_final lanes=%h busy=%b idx=%0d want lanes=1716151413121110 busy=0 idx=0",
                     o_lane_q, o_busy, o_idx);
        end
        $display("test_single_sweep: done_at=%0d lanes=%h", done_at, o_lane_q);
    endtask

    task automatic test_pause();
        int done_at = -1;
        i_data = lanes_of(8'h10); i_mode = 1'b0; i_en = 1'b1; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            i_en = (n >= 5 && n <= 7) ? 1'b0 : 1'b1;
            cyc();
            checks++;
            if ({o_lane_q, o_idx, o_busy, o_done} !== exp_vec()) begin
                errors++;
                $display("FAIL pause_model n=%0d got=%h want=%h", n, {o_lane_q, o_idx, o_busy, o_done}, exp_vec());
            end
            if (n >= 5 && n <= 7) begin
                checks++;
                if (o_idx !== 3'd4 || o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL pause_hold n=%0d idx=%0d done=%b want idx=4 done=0", n, o_idx, o_done);
                end
            end
            if (o_done === 1'b1 && done_at < 0) done_at = n;
        end
        i_en = 1'b1;
        checks++;
        if (done_at != 11) begin
            errors++;
            $display("FAIL pause_done at=%0d want=11", done_at);
        end
        $display("test_pause: done_at=%0d", done_at);
    endtask

    task automatic test_continuous();
        int d1 = -1;
        int d2 = -1;
        int ndone = 0;
        i_data = lanes_of(8'h10); i_mode = 1'b1; i_en = 1'b1; i_start = 1'b1;
        cyc();
        i_start = 1'b0; i_mode = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 9) i_data = lanes_of(8'hA0);
            cyc();
            checks++;
            if ({o_lane_q, o_idx, o_busy, o_done} !== exp_vec()) begin
                errors++;
                $display("FAIL cont_model n=%0d got=%h want=%h", n, {o_lane_q, o_idx, o_busy, o_done}, exp_vec());
            end
            if (o_done === 1'b1) begin
                ndone++;
                if (d1 < 0) d1 = n; else if (d2 < 0) d2 = n;
            end
            if (n == 12) begin
                checks++;
                if (o_lane_q !== 64'h17161514A3A2A1A0) begin
                    errors++;
                    $display("FAIL cont_lanes got=%h want=17161514a3a2a1a0", o_lane_q);
                end
            end
        end
        checks++;
        if (d1 != 8 || d2 != 16 || ndone != 2 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_done d1=%0d d2=%0d count=%0d busy=%b want 8 16 2 1", d1, d2, ndone, o_busy);
        end
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_idx !== 3'd0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL cont_abort busy=%b idx=%0d done=%b want 0 0 0", o_busy, o_idx, o_done);
        end
        $display("test_continuous: done at %0d and %0d", d1, d2);
    endtask

    task automatic test_abort();
        logic [N*W-1:0] prior;
        logic [N*W-1:0] fresh;
        int guard = 0;
        prior = o_lane_q;
        fresh = lanes_of(8'h50);
        i_data = fresh; i_mode = 1'b0; i_en = 1'b1; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        while (o_idx !== 3'd5 && guard < 20) begin
            cyc();
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL abort_reach idx=%0d want=5", o_idx);
        end
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        checks++;
        if (o_lane_q[39:0] !== fresh[39:0] || o_lane_q[63:40] !== prior[63:40]) begin
            errors++;
            $display("FAIL abort_lanes got=%h want=%h", o_lane_q, {prior[63:40], fresh[39:0]});
        end
        checks++;
        if (o_busy !== 1'b0 || o_idx !== 3'd0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state busy=%b idx=%0d done=%b want 0 0 0", o_busy, o_idx, o_done);
        end
        cyc();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone done=%b busy=%b want 0 0", o_done, o_busy);
        end
        i_data = lanes_of(8'h60); i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        cyc();
        checks++;
        if (o_idx !== 3'd1 || o_lane_q[7:0] !== 8'h60) begin
            errors++;
            $display("FAIL abort_restart idx=%0d lane0=%h want idx=1 lane0=60", o_idx, o_lane_q[7:0]);
        end
        for (int n = 0; n < 9; n++) begin
            cyc();
            checks++;
            if ({o_lane_q, o_idx, o_busy, o_done} !== exp_vec()) begin
                errors++;
                $display("FAIL abort_model n=%0d got=%h want=%h", n, {o_lane_q, o_idx, o_busy, o_done}, exp_vec());
            end
        end
        $display("test_abort: lanes=%h", o_lane_q);
    endtask

    task automatic test_restart_and_reset();
        int done_at = -1;
        i_data = lanes_of(8'h20); i_mode = 1'b0; i_en = 1'b1; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 3) begin i_start = 1'b1; i_mode = 1'b1; end
            if (n == 4) begin i_start = 1'b0; i_mode = 1'b0; end
            cyc();
            checks++;
            if ({o_lane_q, o_idx, o_busy, o_done} !== exp_vec()) begin
                errors++;
                $display("FAIL restart_model n=%0d got=%h want=%h", n, {o_lane_q, o_idx, o_busy, o_done}, exp_vec());
            end
            if (o_done === 1'b1 && done_at < 0) done_at = n;
        end
        checks++;
        if (done_at != 8 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored done_at=%0d busy=%b want 8 0", done_at, o_busy);
        end
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        cyc(); cyc(); cyc();
        i_arst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({o_lane_q, o_idx, o_busy, o_done} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", {o_lane_q, o_idx, o_busy, o_done});
        end
        @(posedge i_clk); #1;
        i_arst_n = 1'b1;
        cyc();
        checks++;
        if ({o_lane_q, o_idx, o_busy, o_done} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got=%h want=%h", {o_lane_q, o_idx, o_busy, o_done}, exp_vec());
        end
        $display("test_restart_and_reset: done_at=%0d", done_at);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            i_en    = ($urandom_range(0, 3) != 0);
            i_start = ($urandom_range(0, 3) == 0);
            i_mode  = $urandom_range(0, 1);
            i_abort = ($urandom_range(0, 19) == 0);
            i_data  = {$urandom, $urandom};
            cyc();
            checks++;
            if ({o_lane_q, o_idx, o_busy, o_done} !== exp_vec()) begin
                errors++; bad++;
                $display("FAIL random_model n=%0d got=%h want=%h", n, {o_lane_q, o_idx, o_busy, o_done}, exp_vec());
            end
        end
        i_start = 1'b0; i_abort = 1'b1; i_en = 1'b1;
        cyc();
        i_abort = 1'b0;
        $display("test_random: 400 cycles, %0d bad", bad);
    endtask

`ifdef LANE_SCAN_PARITY_EN
    task automatic test_parity();
        logic [N-1:0] want;
        i_data = lanes_of(8'h00);
        i_data[23:16] = 8'h07;
        i_data[31:24] = 8'h03;
        i_mode = 1'b0; i_en = 1'b1; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        for (int n = 0; n < 9; n++) cyc();
        checks++;
        if (o_par[2] !== 1'b1 || o_par[3] !== 1'b0) begin
            errors++;
            $display("FAIL parity_lanes par2=%b par3=%b want 1 0", o_par[2], o_par[3]);
        end
        for (int k = 0; k < N; k++) want[k] = ^m_lane[k];
        checks++;
        if (o_par !== want) begin
            errors++;
            $display("FAIL parity_all got=%b want=%b", o_par, want);
        end
        $display("test_parity: par=%b", o_par);
    endtask
`endif

    initial begin
        test_reset();
        test_single_sweep();
        test_pause();
        test_continuous();
        test_abort();
        test_restart_and_reset();
        test_random();
`ifdef LANE_SCAN_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
